// File: rtl/gpio_pkg.sv
// ============================================================================
// Module   : gpio_pkg
// Purpose  : Shared register offsets and defaults for the GPIO slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_pkg;

  localparam logic [7:0] GPIO_DATA_OUT = 8'h00;
  localparam logic [7:0] GPIO_DIR      = 8'h04;
  localparam logic [7:0] GPIO_DATA_IN  = 8'h08;
  localparam logic [7:0] GPIO_IRQ_EN   = 8'h0C;
  localparam logic [7:0] GPIO_IRQ_STAT = 8'h10;
  localparam logic [7:0] GPIO_IRQ_EDGE = 8'h14;

  localparam int GPIO_NUM_PINS = 16;

endpackage

`default_nettype wire

// File: rtl/gpio_sync.sv
// ============================================================================
// Module   : gpio_sync
// Purpose  : Multi-stage flop synchronizer for asynchronous pad inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH  = GPIO_NUM_PINS,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gpio_slave.sv
// ============================================================================
// Module   : gpio_slave
// Purpose  : Zero-wait-state memory-mapped GPIO with synchronized inputs and
//            W1C edge interrupts. Define GPIO_BOTH_EDGE_EN for IRQ_EDGE (0x14).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_slave
  import gpio_pkg::*;
#(
  parameter int NUM_PINS    = GPIO_NUM_PINS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bSel,
  input  logic [7:0]          bAddr,
  input  logic                bWrite,
  input  logic [31:0]         bWData,
  output logic [31:0]         bRData,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  // Edges stay blanked until the synchronizer and edge history have flushed
  // whatever the pins held during reset.
  localparam int                   c_BLANK_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [c_BLANK_W-1:0] c_BLANK_MAX = c_BLANK_W'(SYNC_STAGES + 1);

  logic [NUM_PINS-1:0]  r_data_out;
  logic [NUM_PINS-1:0]  r_dir;
  logic [NUM_PINS-1:0]  r_irq_en;
  logic [NUM_PINS-1:0]  r_irq_stat;
  logic [NUM_PINS-1:0]  r_prev;
  logic [c_BLANK_W-1:0] r_blank_cnt;

  logic [NUM_PINS-1:0]  w_data_in;
  logic [NUM_PINS-1:0]  w_wdata;
  logic [NUM_PINS-1:0]  w_edge;
  logic [NUM_PINS-1:0]  w_set;
  logic [NUM_PINS-1:0]  w_clr;
  logic [NUM_PINS-1:0]  w_rsel;
  logic [7:0]           w_off;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_unused_ok;

  assign w_off       = {bAddr[7:2], 2'b00};
  assign w_wr        = bSel & bWrite;
  assign w_rd        = bSel & ~bWrite;
  assign w_wdata     = bWData[NUM_PINS-1:0];
  assign w_unused_ok = &{1'b0, bAddr[1:0], bWData};

  gpio_sync #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (gpio_in),
    .o_q   (w_data_in)
  );

`ifdef GPIO_BOTH_EDGE_EN
  logic [NUM_PINS-1:0] r_irq_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_edge <= '0;
    end else if (w_wr && (w_off == GPIO_IRQ_EDGE)) begin
      r_irq_edge <= w_wdata;
    end
  end

  assign w_edge = (w_data_in ^ r_prev) &
                  ((r_irq_edge & ~w_data_in) | (~r_irq_edge & w_data_in));
`else
  assign w_edge = w_data_in & ~r_prev;
`endif

  assign w_set = (r_blank_cnt == c_BLANK_MAX) ? w_edge : '0;
  assign w_clr = (w_wr && (w_off == GPIO_IRQ_STAT)) ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_out  <= '0;
      r_dir       <= '0;
      r_irq_en    <= '0;
      r_irq_stat  <= '0;
      r_prev      <= '0;
      r_blank_cnt <= '0;
    end else begin
      if (w_wr && (w_off == GPIO_DATA_OUT)) r_data_out <= w_wdata;
      if (w_wr && (w_off == GPIO_DIR))      r_dir      <= w_wdata;
      if (w_wr && (w_off == GPIO_IRQ_EN))   r_irq_en   <= w_wdata;
      // A new edge beats a same-cycle clear of that bit.
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_set;
      r_prev     <= w_data_in;
      if (r_blank_cnt != c_BLANK_MAX) r_blank_cnt <= r_blank_cnt + 1'b1;
    end
  end

  always_comb begin
    w_rsel = '0;
    if (w_rd) begin
      case (w_off)
        GPIO_DATA_OUT: w_rsel = r_data_out;
        GPIO_DIR:      w_rsel = r_dir;
        GPIO_DATA_IN:  w_rsel = w_data_in;
        GPIO_IRQ_EN:   w_rsel = r_irq_en;
        GPIO_IRQ_STAT: w_rsel = r_irq_stat;
`ifdef GPIO_BOTH_EDGE_EN
        GPIO_IRQ_EDGE: w_rsel = r_irq_edge;
`endif
        default:       w_rsel = '0;
      endcase
    end
    bRData                 = '0;
    bRData[NUM_PINS-1:0]   = w_rsel;
  end

  assign gpio_out = r_data_out;
  assign gpio_oe  = r_dir;
  assign irq      = |(r_irq_stat & r_irq_en);

endmodule

`default_nettype wire

// File: tb/tb_gpio_slave.sv
// ============================================================================
// Module   : tb_gpio_slave
// Purpose  : Directed table-driven bench for gpio_slave (NUM_PINS=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_slave;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

`ifdef GPIO_BOTH_EDGE_EN
  localparam logic [31:0] EXP_EDGE_REG = 32'h1;
  localparam logic [31:0] EXP_FALL     = 32'h1;
`else
  localparam logic [31:0] EXP_EDGE_REG = 32'h0;
  localparam logic [31:0] EXP_FALL     = 32'h0;
`endif

  localparam int NVEC = 22;

  logic        clk;
  logic        rst_n;
  logic        bSel;
  logic [7:0]  bAddr;
  logic        bWrite;
  logic [31:0] bWData;
  logic [31:0] bRData;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;
  logic        irq;

  int checks;
  int failures;

  vec_t vecs[NVEC];

  gpio_slave #(
    .NUM_PINS    (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bSel     (bSel),
    .bAddr    (bAddr),
    .bWrite   (bWrite),
    .bWData   (bWData),
    .bRData   (bRData),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle; read data is sampled before the committing edge.
  task automatic apply(input vec_t v, output logic [31:0] rd);
    @(negedge clk);
    bSel   = v.sel;
    bWrite = v.wr;
    bAddr  = v.addr;
    bWData = v.wdata;
    #1;
    rd = bRData;
    @(posedge clk);
    #1;
    bSel   = 1'b0;
    bWrite = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    vec_t        v;
    logic [31:0] rd;
    v = '{1'b1, 1'b1, a, d, 32'h0};
    apply(v, rd);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    vec_t        v;
    logic [31:0] rd;
    v = '{1'b1, 1'b0, a, 32'h0, 32'h0};
    apply(v, rd);
    check(name, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 1'b0, 8'h00, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 1'b0, 8'h04, 32'h0,         32'h0};
    vecs[2]  = '{1'b1, 1'b0, 8'h08, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, 1'b0, 8'h0C, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 1'b0, 8'h10, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 1'b0, 8'h14, 32'h0,         32'h0};
    vecs[6]  = '{1'b1, 1'b0, 8'h18, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 1'b0, 8'hFC, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 1'b1, 8'h04, 32'h0000_00FF, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 32'h1234_A5A5, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 8'h08, 32'h0000_FFFF, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 8'h04, 32'h0,         32'h0000_00FF};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 32'h0,         32'h0000_A5A5};
    vecs[13] = '{1'b1, 1'b0, 8'h08, 32'h0,         32'h0};
    vecs[14] = '{1'b1, 1'b0, 8'h05, 32'h0,         32'h0000_00FF};
    vecs[15] = '{1'b0, 1'b1, 8'h04, 32'h0000_FFFF, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 8'h04, 32'h0,         32'h0000_00FF};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 32'h0,         32'h0};
    vecs[18] = '{1'b1, 1'b1, 8'h14, 32'h0000_0001, 32'h0};
    vecs[19] = '{1'b1, 1'b0, 8'h14, 32'h0,         EXP_EDGE_REG};
    vecs[20] = '{1'b1, 1'b1, 8'h18, 32'h0000_FFFF, 32'h0};
    vecs[21] = '{1'b1, 1'b0, 8'h18, 32'h0,         32'h0};

    rst_n   = 1'b0;
    bSel    = 1'b0;
    bWrite  = 1'b0;
    bAddr   = 8'h00;
    bWData  = 32'h0;
    gpio_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
    check("rst_gpio_oe",  {16'h0, gpio_oe},  32'h0);
    check("rst_irq",      {31'h0, irq},      32'h0);
    check("rst_rdata",    bRData,            32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register map table.
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i], rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    check("map_gpio_oe",  {16'h0, gpio_oe},  32'h0000_00FF);
    check("map_gpio_out", {16'h0, gpio_out}, 32'h0000_A5A5);
    check("map_irq",      {31'h0, irq},      32'h0);

    // Exact input-to-status latency on pin 3.
    wr(8'h0C, 32'h8);
    @(negedge clk);
    gpio_in = 16'h0008;
    bSel    = 1'b1;
    bWrite  = 1'b0;
    bAddr   = 8'h08;
    @(posedge clk); #1;
    check("din_edge1", bRData, 32'h0);
    @(posedge clk); #1;
    check("din_edge2", bRData, 32'h8);
    bAddr = 8'h10;
    #1;
    check("stat_edge2", bRData, 32'h0);
    check("irq_edge2",  {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("stat_edge3", bRData, 32'h8);
    check("irq_edge3",  {31'h0, irq}, 32'h1);
    bSel = 1'b0;

    // Set beats a same-cycle W1C.
    @(negedge clk);
    gpio_in = 16'h0000;
    repeat (4) @(posedge clk);
    wr(8'h10, 32'h8);
    rd_chk("stat_cleared", 8'h10, 32'h0);
    @(negedge clk);
    gpio_in = 16'h0008;
    @(posedge clk);
    @(posedge clk); #1;
    bSel   = 1'b1;
    bWrite = 1'b1;
    bAddr  = 8'h10;
    bWData = 32'h8;
    @(posedge clk); #1;
    bSel   = 1'b0;
    bWrite = 1'b0;
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    rd_chk("stat_set_wins", 8'h10, 32'h8);

    // Masking through IRQ_EN leaves status intact.
    wr(8'h0C, 32'h0);
    check("irq_masked", {31'h0, irq}, 32'h0);
    rd_chk("stat_masked", 8'h10, 32'h8);
    wr(8'h0C, 32'h8);
    check("irq_unmasked", {31'h0, irq}, 32'h1);
    wr(8'h10, 32'h8);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    rd_chk("stat_after_w1c", 8'h10, 32'h0);

    // Pins held high through reset, with a write colliding with reset.
    @(negedge clk);
    rst_n   = 1'b0;
    gpio_in = 16'hFFFF;
    bSel    = 1'b1;
    bWrite  = 1'b1;
    bAddr   = 8'h00;
    bWData  = 32'hFFFF;
    @(posedge clk); #1;
    bSel   = 1'b0;
    bWrite = 1'b0;
    check("rst_wr_gpio_out", {16'h0, gpio_out}, 32'h0);
    check("rst_wr_gpio_oe",  {16'h0, gpio_oe},  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    bSel   = 1'b1;
    bWrite = 1'b0;
    bAddr  = 8'h10;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("blank_stat_c%0d", c), bRData, 32'h0);
    end
    bAddr = 8'h08;
    #1;
    check("blank_din", bRData, 32'h0000_FFFF);
    bSel = 1'b0;

    // Falling edge on pin 0 only registers with IRQ_EDGE support.
    wr(8'h14, 32'h1);
    @(negedge clk);
    gpio_in = 16'hFFFE;
    repeat (4) @(posedge clk);
    rd_chk("fall_stat", 8'h10, EXP_FALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
